// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS decode/control slice: opcode and funct
// values, ALU operation codes, HI/LO result select, MDU operation codes,
// the MDU sequencer state type and the packed D->E control bundle.
package mips_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // ALU operation codes (zero-extended to the ALU control width at the port)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // Writeback result select
  localparam logic [1:0] HILO_ALU = 2'b00;
  localparam logic [1:0] HILO_HI  = 2'b01;
  localparam logic [1:0] HILO_LO  = 2'b10;

  // MDU operations; equal to funct[1:0] of the mult/div group
  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Control bundle carried through the D->E register
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [3:0] alucode;
    logic [1:0] hilo_sel;
    logic       mdu;
    logic [1:0] mdu_op;
  } ctrl_t;

  // A bubble is the all-zero bundle: no writes, ALU add, ALU result, no MDU
  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic is_mdu_funct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// Multiply/divide unit sequencer: tracks how long the MDU is occupied.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// MDU_IDLE | no MDU operation in flight
// MDU_BUSY | operation in flight; cnt_q counts down to 0 on the last cycle
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       an MDU op is being loaded into E on this edge
//   start_div   that op is div/divu (selects DIV_LAT, else MUL_LAT)
//   busy        sequence in progress
//   done        pulse on the final busy cycle
module mdu_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic start_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_RELOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    reload  = start_div ? DIV_RELOAD : MUL_RELOAD;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_BUSY;
          cnt_d   = reload;
        end
      end
      MDU_BUSY: begin
        if (cnt_q == '0) begin
          done = 1'b1;
          // A back-to-back op reloads directly so busy has no idle gap
          if (start) begin
            cnt_d = reload;
          end else begin
            state_d = MDU_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  assign busy = (state_q == MDU_BUSY);

endmodule

// File: rtl/mdu_control_pipe.sv
// Decode-stage control unit for the 5-stage MIPS core with the D->E control
// register and the multiply/divide sequencing/stall logic.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   op_d, funct_d       instruction fields in D
//   equal_d             register compare result in D
//   valid_d             D holds a real instruction
//   flush_e             hazard unit request to bubble E
//   pcsrc_d, branch_d   branch taken / branch present (combinational)
//   sgnzero_d           immediate sign-extend select (combinational)
//   illegal_d           unsupported instruction in D (combinational)
//   stall_req_d         MDU structural stall (combinational)
//   *_e                 registered execute-stage controls
//   mdu_start_e         pulse: MDU op in E
//   mdu_op_e            MDU operation in E
//   mdu_busy, mdu_done  MDU sequence status
module mdu_control_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int ALUC_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        op_d,
  input  logic [5:0]        funct_d,
  input  logic              equal_d,
  input  logic              valid_d,
  input  logic              flush_e,
  output logic              pcsrc_d,
  output logic              branch_d,
  output logic              sgnzero_d,
  output logic              illegal_d,
  output logic              stall_req_d,
  output logic              regwrite_e,
  output logic              memtoreg_e,
  output logic              memwrite_e,
  output logic              alusrc_e,
  output logic              regdst_e,
  output logic [ALUC_W-1:0] alucontrol_e,
  output logic [1:0]        hilo_sel_e,
  output logic              mdu_start_e,
  output logic [1:0]        mdu_op_e,
  output logic              mdu_busy,
  output logic              mdu_done
);

  ctrl_t dec;
  ctrl_t ctrl_e_q, ctrl_e_d;
  logic  legal;
  logic  is_beq;
  logic  is_bne;
  logic  is_mdu;
  logic  is_hilo_rd;
  logic  sgn;

  // Instruction decode
  always_comb begin
    dec        = CTRL_BUBBLE;
    legal      = 1'b1;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_mdu     = 1'b0;
    is_hilo_rd = 1'b0;
    sgn        = 1'b1;
    case (op_d)
      OP_RTYPE: begin
        dec.regwrite = 1'b1;
        dec.regdst   = 1'b1;
        case (funct_d)
          F_ADD, F_ADDU: dec.alucode = ALU_ADD;
          F_SUB, F_SUBU: dec.alucode = ALU_SUB;
          F_AND:         dec.alucode = ALU_AND;
          F_OR:          dec.alucode = ALU_OR;
          F_XOR:         dec.alucode = ALU_XOR;
          F_NOR:         dec.alucode = ALU_NOR;
          F_SLT:         dec.alucode = ALU_SLT;
          F_SLTU:        dec.alucode = ALU_SLTU;
          F_SLL:         dec.alucode = ALU_SLL;
          F_SRL:         dec.alucode = ALU_SRL;
          F_SRA:         dec.alucode = ALU_SRA;
          F_MFHI: begin
            dec.hilo_sel = HILO_HI;
            is_hilo_rd   = 1'b1;
          end
          F_MFLO: begin
            dec.hilo_sel = HILO_LO;
            is_hilo_rd   = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            // Results land in HI/LO inside the MDU, not the register file
            dec.regwrite = 1'b0;
            dec.regdst   = 1'b0;
            dec.mdu      = 1'b1;
            dec.mdu_op   = funct_d[1:0];
            is_mdu       = is_mdu_funct(funct_d);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_SW: begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        dec.alucode = ALU_SUB;
        is_beq      = 1'b1;
      end
      OP_BNE: begin
        dec.alucode = ALU_SUB;
        is_bne      = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        case (op_d)
          OP_SLTI:  dec.alucode = ALU_SLT;
          OP_SLTIU: dec.alucode = ALU_SLTU;
          OP_ANDI: begin
            dec.alucode = ALU_AND;
            sgn         = 1'b0;
          end
          OP_ORI: begin
            dec.alucode = ALU_OR;
            sgn         = 1'b0;
          end
          OP_XORI: begin
            dec.alucode = ALU_XOR;
            sgn         = 1'b0;
          end
          OP_LUI: begin
            dec.alucode = ALU_LUI;
            sgn         = 1'b0;
          end
          default: dec.alucode = ALU_ADD;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  assign illegal_d   = valid_d & ~legal;
  assign sgnzero_d   = sgn;
  assign branch_d    = valid_d & (is_beq | is_bne);
  // done frees the MDU this cycle, so a waiting op may advance on this edge
  assign stall_req_d = valid_d & mdu_busy & ~mdu_done & (is_mdu | is_hilo_rd);
  assign pcsrc_d     = branch_d & (equal_d ^ is_bne) & ~stall_req_d;

  // D->E control register
  always_comb begin
    ctrl_e_d = dec;
    if (flush_e || stall_req_d || !valid_d || !legal) begin
      ctrl_e_d = CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e_q <= CTRL_BUBBLE;
    end else begin
      ctrl_e_q <= ctrl_e_d;
    end
  end

  assign regwrite_e   = ctrl_e_q.regwrite;
  assign memtoreg_e   = ctrl_e_q.memtoreg;
  assign memwrite_e   = ctrl_e_q.memwrite;
  assign alusrc_e     = ctrl_e_q.alusrc;
  assign regdst_e     = ctrl_e_q.regdst;
  assign alucontrol_e = ALUC_W'(ctrl_e_q.alucode);
  assign hilo_sel_e   = ctrl_e_q.hilo_sel;
  assign mdu_start_e  = ctrl_e_q.mdu;
  assign mdu_op_e     = ctrl_e_q.mdu_op;

  // The sequencer sees the op on the same edge that loads it into E, so
  // the cycle carrying mdu_start_e is already the first busy cycle.
  mdu_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_sequencer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ctrl_e_d.mdu),
    .start_div (ctrl_e_d.mdu_op[1]),
    .busy      (mdu_busy),
    .done      (mdu_done)
  );

endmodule

// File: tb/tb_mdu_control_pipe.sv
module tb_mdu_control_pipe;

  logic       clk;
  logic       rst_n;
  logic [5:0] op_d;
  logic [5:0] funct_d;
  logic       equal_d;
  logic       valid_d;
  logic       flush_e;
  logic       pcsrc_d, branch_d, sgnzero_d, illegal_d, stall_req_d;
  logic       regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
  logic [3:0] alucontrol_e;
  logic [1:0] hilo_sel_e;
  logic       mdu_start_e;
  logic [1:0] mdu_op_e;
  logic       mdu_busy, mdu_done;

  int nvec = 0;
  int nerr = 0;

  mdu_control_pipe #(
    .ALUC_W  (4),
    .MUL_LAT (4),
    .DIV_LAT (32),
    .CNT_W   (6)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op_d         (op_d),
    .funct_d      (funct_d),
    .equal_d      (equal_d),
    .valid_d      (valid_d),
    .flush_e      (flush_e),
    .pcsrc_d      (pcsrc_d),
    .branch_d     (branch_d),
    .sgnzero_d    (sgnzero_d),
    .illegal_d    (illegal_d),
    .stall_req_d  (stall_req_d),
    .regwrite_e   (regwrite_e),
    .memtoreg_e   (memtoreg_e),
    .memwrite_e   (memwrite_e),
    .alusrc_e     (alusrc_e),
    .regdst_e     (regdst_e),
    .alucontrol_e (alucontrol_e),
    .hilo_sel_e   (hilo_sel_e),
    .mdu_start_e  (mdu_start_e),
    .mdu_op_e     (mdu_op_e),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic vld,
                       input logic eq, input logic fl);
    op_d    = op;
    funct_d = fn;
    valid_d = vld;
    equal_d = eq;
    flush_e = fl;
    #1;
  endtask

  int nbusy, ndone, nstall, done1, done2, start2;
  logic rel;

  initial begin
    rst_n = 1'b0;
    op_d = '0; funct_d = '0; equal_d = 1'b0; valid_d = 1'b0; flush_e = 1'b0;
    tick();
    tick();
    check("rst_busy", mdu_busy, 0);
    check("rst_done", mdu_done, 0);
    check("rst_regwrite", regwrite_e, 0);
    check("rst_alu", alucontrol_e, 0);
    check("rst_start", mdu_start_e, 0);
    rst_n = 1'b1;
    tick();

    // add, ori, lui back to back
    drive(6'b000000, 6'b100000, 1, 0, 0);
    check("add_sgn", sgnzero_d, 1);
    check("add_illegal", illegal_d, 0);
    tick();
    drive(6'b001101, 6'b000000, 1, 0, 0);
    check("add_alu", alucontrol_e, 0);
    check("add_regdst", regdst_e, 1);
    check("add_regwrite", regwrite_e, 1);
    check("ori_sgn", sgnzero_d, 0);
    tick();
    drive(6'b001111, 6'b000000, 1, 0, 0);
    check("ori_alu", alucontrol_e, 3);
    check("ori_regdst", regdst_e, 0);
    check("ori_alusrc", alusrc_e, 1);
    check("lui_sgn", sgnzero_d, 0);
    tick();
    drive(6'b000000, 6'b000011, 1, 0, 0);
    check("lui_alu", alucontrol_e, 11);
    check("lui_regdst", regdst_e, 0);
    check("lui_regwrite", regwrite_e, 1);
    tick();
    check("sra_alu", alucontrol_e, 10);

    // beq then bne, both with equal_d=1
    drive(6'b000100, 6'b000000, 1, 1, 0);
    check("beq_branch", branch_d, 1);
    check("beq_pcsrc", pcsrc_d, 1);
    tick();
    drive(6'b000101, 6'b000000, 1, 1, 0);
    check("bne_branch", branch_d, 1);
    check("bne_pcsrc", pcsrc_d, 0);
    check("beq_regwrite", regwrite_e, 0);
    check("beq_alu", alucontrol_e, 1);
    tick();
    drive(6'b000101, 6'b000000, 1, 0, 0);
    check("bne_ne_pcsrc", pcsrc_d, 1);
    check("bne_regwrite", regwrite_e, 0);
    check("bne_alu", alucontrol_e, 1);
    tick();

    // illegal opcode, then lw with and without flush
    drive(6'b111111, 6'b000000, 1, 0, 0);
    check("ill_flag", illegal_d, 1);
    check("ill_branch", branch_d, 0);
    tick();
    drive(6'b100011, 6'b000000, 1, 0, 1);
    check("ill_regwrite", regwrite_e, 0);
    check("ill_memwrite", memwrite_e, 0);
    check("ill_alusrc", alusrc_e, 0);
    check("ill_alu", alucontrol_e, 0);
    check("lw_illegal", illegal_d, 0);
    tick();
    drive(6'b100011, 6'b000000, 1, 0, 0);
    check("lwfl_memtoreg", memtoreg_e, 0);
    check("lwfl_regwrite", regwrite_e, 0);
    tick();
    drive(6'b101011, 6'b000000, 1, 0, 0);
    check("lw_memtoreg", memtoreg_e, 1);
    check("lw_alusrc", alusrc_e, 1);
    check("lw_regwrite", regwrite_e, 1);
    tick();
    drive(6'b000000, 6'b100000, 0, 0, 0);
    check("sw_memwrite", memwrite_e, 1);
    check("sw_regwrite", regwrite_e, 0);
    tick();
    check("inv_regwrite", regwrite_e, 0);
    check("inv_illegal", illegal_d, 0);

    // mult followed by mfhi
    drive(6'b000000, 6'b011000, 1, 0, 0);
    check("mult_stall", stall_req_d, 0);
    tick();
    drive(6'b000000, 6'b010000, 1, 0, 0);
    check("mult_start", mdu_start_e, 1);
    check("mult_op", mdu_op_e, 0);
    check("mult_regwrite", regwrite_e, 0);
    for (int i = 0; i < 3; i++) begin
      check("mfhi_stall", stall_req_d, 1);
      check("mult_busy", mdu_busy, 1);
      check("mult_done_early", mdu_done, 0);
      tick();
      check("mult_start_once", mdu_start_e, 0);
    end
    check("mfhi_stall_done", stall_req_d, 0);
    check("mult_done", mdu_done, 1);
    check("mult_busy_last", mdu_busy, 1);
    tick();
    drive(6'b000000, 6'b000000, 0, 0, 0);
    check("mfhi_hilo", hilo_sel_e, 1);
    check("mfhi_regwrite", regwrite_e, 1);
    check("mult_idle", mdu_busy, 0);
    tick();

    // div with divu waiting in D
    drive(6'b000000, 6'b011010, 1, 0, 0);
    tick();
    drive(6'b000000, 6'b011011, 1, 0, 0);
    check("div_start", mdu_start_e, 1);
    check("div_op", mdu_op_e, 2);
    nbusy = 0; ndone = 0; nstall = 0; done1 = 0; done2 = 0; start2 = 0; rel = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!mdu_busy) break;
      nbusy++;
      if (stall_req_d) nstall++;
      if (mdu_done) begin
        ndone++;
        if (ndone == 1) done1 = nbusy;
        else done2 = nbusy;
      end
      if (c > 0 && mdu_start_e) begin
        start2 = nbusy;
        check("divu_op", mdu_op_e, 3);
      end
      if (valid_d && !stall_req_d) rel = 1'b1;
      tick();
      if (rel) begin
        valid_d = 1'b0;
        rel = 1'b0;
      end
      #1;
    end
    check("div_busy_cycles", nbusy, 64);
    check("div_done_count", ndone, 2);
    check("div_done1_cycle", done1, 32);
    check("div_done2_cycle", done2, 64);
    check("divu_start_cycle", start2, 33);
    check("divu_stall_cycles", nstall, 31);
    check("div_idle_after", mdu_busy, 0);

    // reset in the middle of a div, with a live ori in E
    drive(6'b000000, 6'b011010, 1, 0, 0);
    tick();
    drive(6'b000000, 6'b000000, 0, 0, 0);
    repeat (8) tick();
    drive(6'b001101, 6'b000000, 1, 0, 0);
    tick();
    check("mid_busy", mdu_busy, 1);
    check("mid_regwrite", regwrite_e, 1);
    check("mid_alu", alucontrol_e, 3);
    rst_n = 1'b0;
    #1;
    check("arst_busy", mdu_busy, 0);
    check("arst_done", mdu_done, 0);
    check("arst_regwrite", regwrite_e, 0);
    check("arst_alusrc", alusrc_e, 0);
    check("arst_alu", alucontrol_e, 0);
    check("arst_start", mdu_start_e, 0);
    drive(6'b000000, 6'b000000, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (mdu_done) ndone++;
      if (mdu_busy) nbusy++;
      tick();
    end
    check("arst_no_done", ndone, 0);
    check("arst_no_busy", nbusy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
